mem_bus_bridge: RTL
===================

// Module: mem_bus_bridge
// PURPOSE
//  Downstream neighbour of the LSU mem stage. Accepts one decoupled memory request {a, we, be, d},
//  runs it as a single Wishbone B4 classic master cycle, and returns read data on a decoupled response.
//  Strictly one transaction in flight; a timeout watchdog guarantees every request gets a response.
// PARAMETERS
//  ADDR_WIDTH  32   request/bus address width (byte address, word aligned by requester)
//  DATA_WIDTH  32   data bus width; be width = DATA_WIDTH/8
//  TIMEOUT     255  cycles with stb high and no ack/err before forced abort; 0 disables watchdog
// PORTS
//  clk         in   1             clock
//  rst         in   1             synchronous, active-low reset
//  req         decoupled.in       mem request: data.a[ADDR_WIDTH], data.we, data.be[DW/8], data.d[DW]
//  resp        decoupled.out      mem response: data[DW] (read data; 0 for writes/errors)
//  bus_err     out  1             1-cycle pulse coincident with resp fire when transfer ended in err/timeout
//  wb_cyc_o    out  1             Wishbone cycle
//  wb_stb_o    out  1             Wishbone strobe
//  wb_we_o     out  1             Wishbone write enable
//  wb_adr_o    out  ADDR_WIDTH    Wishbone address
//  wb_sel_o    out  DW/8          Wishbone byte select
//  wb_dat_o    out  DW            Wishbone write data
//  wb_dat_i    in   DW            Wishbone read data
//  wb_ack_i    in   1             Wishbone ack
//  wb_err_i    in   1             Wishbone error
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE; wb_cyc_o/wb_stb_o/wb_we_o=0; adr/sel/dat_o=0; resp.valid=0;
//   resp.data=0; bus_err=0; timer=0. Reset mid-transfer drops cyc immediately; transfer is abandoned.
//  FSM states: IDLE, BUS, RESP.
//   IDLE: req.ready=1. On req fire: latch a/we/be/d into wb_*_o, set cyc=stb=1, timer=0 -> BUS.
//   BUS : req.ready=0. cyc=stb=1, outputs stable. Priority: ack > err > timeout.
//         ack: cyc=stb=0; rdata = we ? 0 : wb_dat_i; err_flag=0 -> RESP.
//         err (no ack): cyc=stb=0; rdata=0; err_flag=1 -> RESP.
//         timer==TIMEOUT-1 with no ack/err (TIMEOUT!=0): same as err -> RESP.
//         else timer++ (saturating; never wraps while TIMEOUT==0).
//   RESP: req.ready=0; resp.valid=1, resp.data=rdata held stable; bus_err=err_flag & resp.ready.
//         On resp fire -> IDLE (next request accepted no earlier than the following cycle).
//  Latency: req fire in cycle N -> stb high N+1; ack sampled in cycle M>=N+1 -> resp.valid in M+1.
//   Minimum req-fire to resp-fire = 2 cycles; throughput 1 request per 3 cycles at zero wait states.
//  Handshake: resp.valid, once high, stays high with constant data until resp.ready. req fields are
//   sampled only on req fire; later changes on req.data are ignored. ack/err outside BUS are ignored.
//  Writes: wb_dat_o=d, wb_sel_o=be as given (pre-shifted by requester); be==0 is still issued on bus.
//  No combinational path from wb_*_i to any output; all outputs registered.
// TESTING
//  1. Zero-wait read: req a=0x100, we=0, be=0xF; slave acks in first BUS cycle with 0xDEADBEEF
//     -> stb high 1 cycle, resp.valid 2 cycles after req fire, data=0xDEADBEEF, bus_err=0.
//  2. Write with 3 wait states: a=0x204, we=1, be=0x4, d=0x00AB0000 -> adr/sel/dat_o/we stable 4
//     cycles, resp.data=0, bus_err=0, req.ready low throughout.
//  3. Backpressure: resp.ready=0 for 5 cycles after ack -> resp.valid/data held, no new req accepted,
//     cyc stays 0; on ready fire returns to IDLE.
//  4. Error: slave asserts err on cycle 2 -> resp.data=0, bus_err pulses once at resp fire.
//  5. Timeout: TIMEOUT=8, slave silent -> cyc drops after exactly 8 stb cycles, bus_err=1; late ack
//     arriving in RESP/IDLE ignored.
//  6. Reset mid-BUS: drive rst=0 during wait state -> next cycle cyc=stb=0, resp.valid=0, req.ready=1
//     after release; next read completes normally.

Source files
------------

// File: rtl/mem_bus_bridge.sv
// Single-outstanding bridge from a decoupled memory request/response pair to a
// Wishbone B4 classic master. A watchdog forces completion if the slave never answers.
module mem_bus_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_a,
  input  logic                    req_we,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [DATA_WIDTH-1:0]   req_d,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    bus_err,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH/8-1:0] sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    timed_out;

  assign timed_out = (TIMEOUT != 0) && (timer_q == TLAST);

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    adr_d        = adr_q;
    sel_d        = sel_q;
    dat_d        = dat_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    resp_valid_d = resp_valid_q;
    timer_d      = timer_q;
    req_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          adr_d   = req_a;
          we_d    = req_we;
          sel_d   = req_be;
          dat_d   = req_d;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          timer_d = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // ack wins over err, err wins over the watchdog
        if (wb_ack_i) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          rdata_d      = we_q ? '0 : wb_dat_i;
          err_d        = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else if (wb_err_i || timed_out) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          rdata_d      = '0;
          err_d        = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      dat_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      sel_q        <= sel_d;
      dat_q        <= dat_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      timer_q      <= timer_d;
    end
  end

  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_sel_o   = sel_q;
  assign wb_dat_o   = dat_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = rdata_q;
  assign bus_err    = resp_valid_q & err_q & resp_ready;

endmodule
